// File: rtl/led_pwm_pkg.sv
// ---------------------------------------------------------------------------
// led_pwm_pkg
// Shared definitions for the multi-channel LED PWM controller.
//   mode_e        : per-channel output mode (off / static / blink / breathe)
//   cfg_ch_w()    : width of the channel-select field for a channel count
//   cnt_w()       : width of a counter that runs 0..n-1
// ---------------------------------------------------------------------------
package led_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_STATIC  = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

    // A single channel still gets a 1-bit select so the port never collapses.
    function automatic int cfg_ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Width needed to count 0..n-1; at least one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// ---------------------------------------------------------------------------
// led_pwm_channel
// One PWM channel: double-buffered duty/mode (shadow + active), breathe ramp
// with direction flag, blink phase, effective-duty select and output flop.
//
// Optional build macro: LED_PWM_GAMMA_EN squares the effective duty
// ((e*e) >> DUTY_W) before the compare; the square is combinational and
// shares the output register, so latency is the same as the linear build.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   en_i          : global enable; output is forced low when clear
//   wr_i          : load shadow with wr_duty_i / wr_mode_i
//   apply_i       : copy shadow into active (period boundary or en low)
//   step_i        : period boundary; advances the breathe ramp
//   blink_tgl_i   : toggle blink phase (shared blink counter terminal)
//   cnt_i         : shared PWM period counter
//   pwm_o         : registered PWM output, active-high
// ---------------------------------------------------------------------------
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              wr_i,
    input  logic [DUTY_W-1:0] wr_duty_i,
    input  mode_e             wr_mode_i,
    input  logic              apply_i,
    input  logic              step_i,
    input  logic              blink_tgl_i,
    input  logic [DUTY_W-1:0] cnt_i,
    output logic              pwm_o
);

    logic [DUTY_W-1:0] sh_duty_q,  sh_duty_d;
    mode_e             sh_mode_q,  sh_mode_d;
    logic [DUTY_W-1:0] act_duty_q, act_duty_d;
    mode_e             act_mode_q, act_mode_d;
    logic [DUTY_W-1:0] ramp_q,     ramp_d;
    logic              dir_dn_q,   dir_dn_d;
    logic              phase_on_q, phase_on_d;
    logic              pwm_q,      pwm_d;

    logic [DUTY_W-1:0] eff_duty;
    logic [DUTY_W-1:0] cmp_duty;

    // One breathe step toward duty; returns {dir_dn, ramp}.
    // Direction turns down on reaching duty and up on reaching zero, so the
    // ramp stays inside 0..duty without wrapping either way.
    function automatic logic [DUTY_W:0] breathe_step(
        input logic [DUTY_W-1:0] ramp,
        input logic              dir_dn,
        input logic [DUTY_W-1:0] duty
    );
        logic [DUTY_W-1:0] r;
        logic              d;
        r = ramp;
        d = dir_dn;
        if (duty == '0) begin
            r = '0;
            d = 1'b0;
        end else if (!dir_dn) begin
            if (ramp < duty) begin
                r = ramp + 1'b1;
                d = (r == duty);
            end else begin
                r = duty;
                d = 1'b1;
            end
        end else begin
            if (ramp != '0) begin
                r = ramp - 1'b1;
                d = (r != '0);
            end else begin
                d = 1'b0;
            end
        end
        return {d, r};
    endfunction

    always_comb begin
        sh_duty_d  = sh_duty_q;
        sh_mode_d  = sh_mode_q;
        act_duty_d = act_duty_q;
        act_mode_d = act_mode_q;
        ramp_d     = ramp_q;
        dir_dn_d   = dir_dn_q;
        phase_on_d = phase_on_q;

        // A write and an apply in the same cycle: active takes the old
        // shadow, the new shadow waits for the following boundary.
        if (wr_i) begin
            sh_duty_d = wr_duty_i;
            sh_mode_d = wr_mode_i;
        end

        if (apply_i) begin
            act_duty_d = sh_duty_q;
            act_mode_d = sh_mode_q;
            if (sh_mode_q != act_mode_q) begin
                ramp_d     = '0;
                dir_dn_d   = 1'b0;
                phase_on_d = 1'b1;
            end else begin
                // Same mode, new duty: pull the ramp down so it never sits
                // above the duty it is tracking.
                if (ramp_q > sh_duty_q) begin
                    ramp_d = sh_duty_q;
                end
                if (blink_tgl_i) begin
                    phase_on_d = ~phase_on_q;
                end
            end
        end else begin
            if (blink_tgl_i) begin
                phase_on_d = ~phase_on_q;
            end
            if (step_i && (act_mode_q == MODE_BREATHE)) begin
                {dir_dn_d, ramp_d} = breathe_step(ramp_q, dir_dn_q, act_duty_q);
            end
        end
    end

    always_comb begin
        eff_duty = '0;
        case (act_mode_q)
            MODE_OFF:     eff_duty = '0;
            MODE_STATIC:  eff_duty = act_duty_q;
            MODE_BLINK:   eff_duty = phase_on_q ? act_duty_q : '0;
            MODE_BREATHE: eff_duty = ramp_q;
            default:      eff_duty = '0;
        endcase
    end

`ifdef LED_PWM_GAMMA_EN
    logic [2*DUTY_W-1:0] eff_sq;
    assign eff_sq   = {{DUTY_W{1'b0}}, eff_duty} * {{DUTY_W{1'b0}}, eff_duty};
    assign cmp_duty = eff_sq[2*DUTY_W-1:DUTY_W];
`else
    assign cmp_duty = eff_duty;
`endif

    // Full-scale duty still loses the cnt == max tick: there is no 100% state.
    assign pwm_d = en_i && (cnt_i < cmp_duty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_duty_q  <= '0;
            sh_mode_q  <= MODE_OFF;
            act_duty_q <= '0;
            act_mode_q <= MODE_OFF;
            ramp_q     <= '0;
            dir_dn_q   <= 1'b0;
            phase_on_q <= 1'b1;
            pwm_q      <= 1'b0;
        end else begin
            sh_duty_q  <= sh_duty_d;
            sh_mode_q  <= sh_mode_d;
            act_duty_q <= act_duty_d;
            act_mode_q <= act_mode_d;
            ramp_q     <= ramp_d;
            dir_dn_q   <= dir_dn_d;
            phase_on_q <= phase_on_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// ---------------------------------------------------------------------------
// led_pwm_ctrl
// Multi-channel LED PWM controller running from the low-frequency oscillator.
// Holds the tick prescaler, the shared period counter, the blink counter and
// the config handshake; each output is an led_pwm_channel instance.
//
// Optional build macro: LED_PWM_GAMMA_EN (perceptual square of the duty,
// applied inside each channel; latency unchanged).
//
// Ports
//   clk           : system clock (int_osc)
//   rst           : asynchronous active-high reset
//   en            : global enable; low clears counters and forces outputs low
//   cfg_valid     : config write request
//   cfg_ready     : config slot free (no shadow update waiting to apply)
//   cfg_ch        : target channel; out-of-range values are accepted, dropped
//   cfg_duty      : requested duty
//   cfg_mode      : 00 off, 01 static, 10 blink, 11 breathe
//   pwm_o         : PWM outputs, active-high, one cycle behind the counter
//   period_start  : one-cycle pulse on the tick that wraps the counter
// ---------------------------------------------------------------------------
module led_pwm_ctrl
    import led_pwm_pkg::*;
#(
    parameter int CHANNELS      = 3,
    parameter int DUTY_W        = 8,
    parameter int PRESC_DIV     = 4,
    parameter int BLINK_PERIODS = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [cfg_ch_w(CHANNELS)-1:0] cfg_ch,
    input  logic [DUTY_W-1:0]             cfg_duty,
    input  logic [1:0]                    cfg_mode,
    output logic [CHANNELS-1:0]           pwm_o,
    output logic                          period_start
);

    localparam int CH_W  = cfg_ch_w(CHANNELS);
    localparam int PRE_W = cnt_w(PRESC_DIV);
    localparam int BLK_W = cnt_w(BLINK_PERIODS);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESC_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_PERIODS - 1);
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNELS);

    logic [PRE_W-1:0]  presc_q,   presc_d;
    logic [DUTY_W-1:0] cnt_q,     cnt_d;
    logic [BLK_W-1:0]  blink_q,   blink_d;
    logic              pending_q, pending_d;

    logic tick;
    logic wrap;
    logic blink_tgl;
    logic xfer;
    logic ch_in_range;
    logic wr_ok;
    logic apply;

    // Timebase: tick on prescaler terminal; period boundary when the counter
    // is about to wrap on that tick.
    assign tick      = en && (presc_q == PRE_LAST);
    assign wrap      = tick && (cnt_q == {DUTY_W{1'b1}});
    assign blink_tgl = wrap && (blink_q == BLK_LAST);

    assign period_start = wrap;

    // Config handshake. An out-of-range channel completes the handshake but
    // leaves pending clear, so the next write is not held up for nothing.
    assign cfg_ready   = ~pending_q;
    assign xfer        = cfg_valid && cfg_ready;
    assign ch_in_range = ({1'b0, cfg_ch} < CH_LIMIT);
    assign wr_ok       = xfer && ch_in_range;

    // With en low there is no boundary to wait for, so apply straight away.
    assign apply = pending_q && (wrap || !en);

    always_comb begin
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        blink_d   = blink_q;
        pending_d = pending_q;

        if (!en) begin
            presc_d = '0;
            cnt_d   = '0;
            blink_d = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (wrap) begin
                blink_d = (blink_q == BLK_LAST) ? '0 : blink_q + 1'b1;
            end
        end

        // A new write on the apply cycle re-arms pending for the next
        // boundary rather than being lost.
        if (wr_ok) begin
            pending_d = 1'b1;
        end else if (apply) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            cnt_q     <= '0;
            blink_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            blink_q   <= blink_d;
            pending_q <= pending_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        led_pwm_channel #(
            .DUTY_W (DUTY_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .en_i        (en),
            .wr_i        (wr_ok && (cfg_ch == CH_W'(c))),
            .wr_duty_i   (cfg_duty),
            .wr_mode_i   (mode_e'(cfg_mode)),
            .apply_i     (apply),
            .step_i      (wrap),
            .blink_tgl_i (blink_tgl),
            .cnt_i       (cnt_q),
            .pwm_o       (pwm_o[c])
        );
    end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_pwm_ctrl
// Scoreboard bench for led_pwm_ctrl with CHANNELS=3, DUTY_W=4, PRESC_DIV=2,
// BLINK_PERIODS=2 (one PWM period = 32 clk). Each period's expected outputs
// are pushed per clock before the period runs and popped on each falling
// edge. Honours LED_PWM_GAMMA_EN when the build defines it.
// ---------------------------------------------------------------------------
module tb_led_pwm_ctrl;

    localparam int CHANNELS      = 3;
    localparam int DUTY_W        = 4;
    localparam int PRESC_DIV     = 2;
    localparam int BLINK_PERIODS = 2;
    localparam int PERIOD_CLK    = (1 << DUTY_W) * PRESC_DIV;

    localparam int M_OFF     = 0;
    localparam int M_STATIC  = 1;
    localparam int M_BLINK   = 2;
    localparam int M_BREATHE = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en = 1'b0;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [1:0]          cfg_ch = '0;
    logic [DUTY_W-1:0]   cfg_duty = '0;
    logic [1:0]          cfg_mode = '0;
    logic [CHANNELS-1:0] pwm_o;
    logic                period_start;

    led_pwm_ctrl #(
        .CHANNELS      (CHANNELS),
        .DUTY_W        (DUTY_W),
        .PRESC_DIV     (PRESC_DIV),
        .BLINK_PERIODS (BLINK_PERIODS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_duty     (cfg_duty),
        .cfg_mode     (cfg_mode),
        .pwm_o        (pwm_o),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CHANNELS-1:0] pwm;
        logic                ps;
    } exp_t;

    exp_t sb[$];
    exp_t want;
    int   errors = 0;
    int   checks = 0;
    int   cyc;
    bit   ok;

    function automatic int eff(input int e);
`ifdef LED_PWM_GAMMA_EN
        return (e * e) >> DUTY_W;
`else
        return e;
`endif
    endfunction

    // Cycle j=1 follows the boundary pulse; the output lags the counter by
    // one clock, so the high window is j = 2 .. 2 + PRESC_DIV*e - 1.
    task automatic push_period(input int e0, input int e1, input int e2);
        int   e [CHANNELS];
        exp_t w;
        e[0] = eff(e0);
        e[1] = eff(e1);
        e[2] = eff(e2);
        for (int j = 1; j <= PERIOD_CLK; j++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                w.pwm[c] = (j >= 2) && (((j - 2) / PRESC_DIV) < e[c]);
            end
            w.ps = (j == PERIOD_CLK);
            sb.push_back(w);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called on a falling edge; returns on the falling edge after the transfer.
    task automatic cfg_write(input int ch, input int duty, input int mode, output bit done);
        int n;
        n         = 0;
        cfg_ch    = 2'(ch);
        cfg_duty  = DUTY_W'(duty);
        cfg_mode  = 2'(mode);
        cfg_valid = 1'b1;
        while (cfg_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        done = (n < 200);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Returns on the falling edge of a cycle with period_start high
    // (the current cycle counts).
    task automatic wait_ps(output bit found);
        int n;
        n = 0;
        while (period_start !== 1'b1 && n < 4 * PERIOD_CLK) begin
            @(negedge clk);
            n++;
        end
        found = (period_start === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (pwm_o !== '0) begin
            errors++;
            $display("FAIL reset_pwm: pwm_o=%b expected 000", pwm_o);
        end
        checks++;
        if (period_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_ps: period_start=%b expected 0", period_start);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: cfg_ready=%b expected 1", cfg_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (pwm_o !== '0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: pwm_o=%b cfg_ready=%b expected 000 / 1", pwm_o, cfg_ready);
        end
    endtask

    task automatic test_static();
        do_reset();
        en = 1'b1;
        @(negedge clk);
        cfg_write(0, 4, M_STATIC, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL static_write: handshake timed out"); end
        wait_ps(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL static_boundary: no period_start seen"); end
        push_period(4, 0, 0);
        push_period(4, 0, 0);
        cyc = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            want = sb.pop_front();
            checks++;
            if ({pwm_o, period_start} !== want) begin
                errors++;
                $display("FAIL static_cycle %0d: pwm_o=%b period_start=%b, expected pwm_o=%b period_start=%b",
                         cyc, pwm_o, period_start, want.pwm, want.ps);
            end
            cyc++;
        end
    endtask

    // Runs straight after test_static: ch0 static 4 still active.
    task automatic test_back_to_back();
        bit stall_bad;
        int n;
        cfg_write(1, 6, M_STATIC, ok);
        checks++;
        if (cfg_ready !== 1'b0 || !ok) begin
            errors++;
            $display("FAIL b2b_pending: cfg_ready=%b expected 0 after first write", cfg_ready);
        end
        cfg_ch    = 2'd1;
        cfg_duty  = 4'd2;
        cfg_mode  = 2'(M_STATIC);
        cfg_valid = 1'b1;
        stall_bad = 1'b0;
        n = 0;
        while (period_start !== 1'b1 && n < 4 * PERIOD_CLK) begin
            if (cfg_ready !== 1'b0) stall_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        checks++;
        if (period_start !== 1'b1 || stall_bad || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall: stall_broken=%0d cfg_ready_at_boundary=%b expected stall held to boundary (0)",
                     stall_bad, cfg_ready);
        end
        push_period(4, 6, 0);
        push_period(4, 2, 0);
        cyc = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            want = sb.pop_front();
            checks++;
            if ({pwm_o, period_start} !== want) begin
                errors++;
                $display("FAIL b2b_cycle %0d: pwm_o=%b period_start=%b, expected pwm_o=%b period_start=%b",
                         cyc, pwm_o, period_start, want.pwm, want.ps);
            end
            if (cyc == 0) begin
                checks++;
                if (cfg_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_release: cfg_ready=%b expected 1 after boundary", cfg_ready);
                end
            end
            if (cyc == 1) begin
                cfg_valid = 1'b0;
                checks++;
                if (cfg_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_second_accept: cfg_ready=%b expected 0", cfg_ready);
                end
            end
            cyc++;
        end
    endtask

    task automatic test_blink();
        do_reset();
        cfg_write(2, 15, M_BLINK, ok);
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1 || !ok) begin
            errors++;
            $display("FAIL blink_apply_en_low: cfg_ready=%b expected 1", cfg_ready);
        end
        en = 1'b1;
        wait_ps(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL blink_boundary: no period_start seen"); end
        // Periods 1..5 after enable: on, off, off, on, on.
        push_period(0, 0, 15);
        push_period(0, 0, 0);
        push_period(0, 0, 0);
        push_period(0, 0, 15);
        push_period(0, 0, 15);
        cyc = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            want = sb.pop_front();
            checks++;
            if ({pwm_o, period_start} !== want) begin
                errors++;
                $display("FAIL blink_cycle %0d: pwm_o=%b period_start=%b, expected pwm_o=%b period_start=%b",
                         cyc, pwm_o, period_start, want.pwm, want.ps);
            end
            cyc++;
        end
        // Channel 3 does not exist: accepted, no pending, no effect.
        cfg_write(3, 9, M_STATIC, ok);
        checks++;
        if (cfg_ready !== 1'b1 || !ok) begin
            errors++;
            $display("FAIL bad_ch_ready: cfg_ready=%b expected 1", cfg_ready);
        end
        wait_ps(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bad_ch_boundary: no period_start seen"); end
        push_period(0, 0, 0);
        push_period(0, 0, 15);
        cyc = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            want = sb.pop_front();
            checks++;
            if ({pwm_o, period_start} !== want) begin
                errors++;
                $display("FAIL bad_ch_cycle %0d: pwm_o=%b period_start=%b, expected pwm_o=%b period_start=%b",
                         cyc, pwm_o, period_start, want.pwm, want.ps);
            end
            cyc++;
        end
    endtask

    task automatic test_breathe();
        do_reset();
        cfg_write(0, 3, M_BREATHE, ok);
        @(negedge clk);
        en = 1'b1;
        wait_ps(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL breathe_boundary: no period_start seen"); end
        push_period(1, 0, 0);
        push_period(2, 0, 0);
        push_period(3, 0, 0);
        push_period(2, 0, 0);
        push_period(1, 0, 0);
        push_period(0, 0, 0);
        push_period(1, 0, 0);
        cyc = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            want = sb.pop_front();
            checks++;
            if ({pwm_o, period_start} !== want) begin
                errors++;
                $display("FAIL breathe_cycle %0d: pwm_o=%b period_start=%b, expected pwm_o=%b period_start=%b",
                         cyc, pwm_o, period_start, want.pwm, want.ps);
            end
            cyc++;
        end
        cfg_write(0, 0, M_BREATHE, ok);
        wait_ps(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL breathe0_boundary: no period_start seen"); end
        push_period(0, 0, 0);
        push_period(0, 0, 0);
        cyc = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            want = sb.pop_front();
            checks++;
            if ({pwm_o, period_start} !== want) begin
                errors++;
                $display("FAIL breathe0_cycle %0d: pwm_o=%b period_start=%b, expected pwm_o=%b period_start=%b",
                         cyc, pwm_o, period_start, want.pwm, want.ps);
            end
            cyc++;
        end
    endtask

    task automatic test_reset_midperiod();
        int n;
        do_reset();
        en = 1'b1;
        cfg_write(1, 15, M_STATIC, ok);
        wait_ps(ok);
        n = 0;
        while (pwm_o[1] !== 1'b1 && n < 2 * PERIOD_CLK) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pwm_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: pwm_o=%b expected bit1 high", pwm_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pwm_o !== '0) begin
            errors++;
            $display("FAIL midreset_async: pwm_o=%b expected 000 before next clock edge", pwm_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pwm_o !== '0 || cfg_ready !== 1'b1 || period_start !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: pwm_o=%b cfg_ready=%b period_start=%b expected 000 1 0",
                     pwm_o, cfg_ready, period_start);
        end
        en = 1'b0;
        @(negedge clk);
        cfg_write(0, 5, M_STATIC, ok);
        checks++;
        if (cfg_ready !== 1'b0 || !ok) begin
            errors++;
            $display("FAIL enlow_pending: cfg_ready=%b expected 0 right after write", cfg_ready);
        end
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL enlow_apply: cfg_ready=%b expected 1 one cycle later", cfg_ready);
        end
        en = 1'b1;
        wait_ps(ok);
        push_period(5, 0, 0);
        cyc = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            want = sb.pop_front();
            checks++;
            if ({pwm_o, period_start} !== want) begin
                errors++;
                $display("FAIL enlow_cycle %0d: pwm_o=%b period_start=%b, expected pwm_o=%b period_start=%b",
                         cyc, pwm_o, period_start, want.pwm, want.ps);
            end
            cyc++;
        end
    endtask

    task automatic test_gamma();
        do_reset();
        cfg_write(0, 8, M_STATIC, ok);
        @(negedge clk);
        cfg_write(1, 15, M_STATIC, ok);
        @(negedge clk);
        en = 1'b1;
        wait_ps(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL gamma_boundary: no period_start seen"); end
        push_period(8, 15, 0);
        cyc = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            want = sb.pop_front();
            checks++;
            if ({pwm_o, period_start} !== want) begin
                errors++;
                $display("FAIL gamma_cycle %0d: pwm_o=%b period_start=%b, expected pwm_o=%b period_start=%b",
                         cyc, pwm_o, period_start, want.pwm, want.ps);
            end
            cyc++;
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_back_to_back();
        test_blink();
        test_breathe();
        test_reset_midperiod();
        test_gamma();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
